aes128_encryptor: RTL and testbench

Iterative AES-128 encryption core (FIPS-197 cipher direction only) computing one round per clock with on-the-fly key expansion. It accepts a 128-bit plaintext and 128-bit key on a single-cycle start strobe and returns the ciphertext with a one-cycle valid pulse. It is the datapath block of the AES128 encryptor top level, driven by a host or a simple controller.

---
 rtl/aes128_pkg.sv | 31 +++
 rtl/aes_sbox.sv | 27 ++
 rtl/aes128_encryptor.sv | 143 ++++++++++++++
 tb/tb_aes128_encryptor.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/aes128_pkg.sv
// rtl/aes128_pkg.sv - shared AES-128 constants, FSM state type and GF(2^8) helpers
package aes128_pkg;

  localparam int WIDTH      = 128;
  localparam int NUM_ROUNDS = 10;

  typedef enum logic {ST_IDLE, ST_RUN} fsm_e;

  // Indexed directly by the 4-bit round counter; entries 0 and 11..15 are never used
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box (GF(2^8) inverse plus affine map)
module aes_sbox
  import aes128_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  logic [7:0] p2, p4, p8, p16, p32, p64, p128;
  logic [7:0] inv;

  // Multiplicative inverse as x^254; x^254 of zero is zero, which is what the cipher needs
  always_comb begin
    p2   = gf_mul(in_i, in_i);
    p4   = gf_mul(p2, p2);
    p8   = gf_mul(p4, p4);
    p16  = gf_mul(p8, p8);
    p32  = gf_mul(p16, p16);
    p64  = gf_mul(p32, p32);
    p128 = gf_mul(p64, p64);
    inv  = gf_mul(gf_mul(gf_mul(p2, p4), gf_mul(p8, p16)),
                  gf_mul(gf_mul(p32, p64), p128));
    out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes128_encryptor.sv
// rtl/aes128_encryptor.sv - iterative AES-128 encryptor, one round per clock; AES128_CT_MASK_EN zeroes ciphertext_o outside valid_o
module aes128_encryptor
  import aes128_pkg::*;
#(
  parameter int WIDTH = aes128_pkg::WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start,
  input  logic [WIDTH-1:0] plaintext_i,
  input  logic [WIDTH-1:0] key_i,
  output logic             data_ready_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] ciphertext_o
);

  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] rk_q, rk_d;
  logic [3:0]       round_q, round_d;
  logic [WIDTH-1:0] ct_q, ct_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [7:0]       sb_out [16];
  logic [7:0]       ks_out [4];
  logic [31:0]      rot_word;

  assign rot_word = {rk_q[23:0], rk_q[31:24]};

  for (genvar g = 0; g < 16; g++) begin : g_sub_bytes
    aes_sbox u_sbox (
      .in_i  (state_q[127-8*g -: 8]),
      .out_o (sb_out[g])
    );
  end

  for (genvar g = 0; g < 4; g++) begin : g_sub_word
    aes_sbox u_sbox (
      .in_i  (rot_word[31-8*g -: 8]),
      .out_o (ks_out[g])
    );
  end

  logic [7:0]       sr [16];
  logic [7:0]       mc [16];
  logic [31:0]      temp_w, w0, w1, w2, w3;
  logic [WIDTH-1:0] next_rk;
  logic [WIDTH-1:0] round_out;

  always_comb begin
    // Byte r+4c is row r of column c; ShiftRows rotates row r left by r columns
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[r + 4*c] = sb_out[r + 4*((c + r) % 4)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end

    temp_w  = {ks_out[0] ^ RCON[round_q], ks_out[1], ks_out[2], ks_out[3]};
    w0      = rk_q[127:96] ^ temp_w;
    w1      = rk_q[95:64] ^ w0;
    w2      = rk_q[63:32] ^ w1;
    w3      = rk_q[31:0] ^ w2;
    next_rk = {w0, w1, w2, w3};

    round_out = '0;
    for (int i = 0; i < 16; i++) begin
      round_out[127-8*i -: 8] = ((round_q == 4'(NUM_ROUNDS)) ? sr[i] : mc[i])
                              ^ next_rk[127-8*i -: 8];
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    ct_d    = ct_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          state_d = plaintext_i ^ key_i;
          rk_d    = key_i;
          round_d = 4'd1;
          busy_d  = 1'b1;
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = round_out;
        rk_d    = next_rk;
        round_d = round_q + 4'd1;
        if (round_q == 4'(NUM_ROUNDS)) begin
          ct_d    = round_out;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          round_d = 4'd0;
          fsm_d   = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      rk_q    <= '0;
      round_q <= '0;
      ct_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      ct_q    <= ct_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o       = busy_q;
  assign data_ready_o = ~busy_q;
  assign valid_o      = valid_q;
`ifdef AES128_CT_MASK_EN
  assign ciphertext_o = valid_q ? ct_q : '0;
`else
  assign ciphertext_o = ct_q;
`endif

endmodule

// File: tb/tb_aes128_encryptor.sv
// tb/tb_aes128_encryptor.sv - randomized self-checking bench for aes128_encryptor against a byte-level AES model
module tb_aes128_encryptor;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start;
  logic [127:0] plaintext_i;
  logic [127:0] key_i;
  logic         data_ready_o;
  logic         busy_o;
  logic         valid_o;
  logic [127:0] ciphertext_o;

  always #5 clk_i = ~clk_i;

  aes128_encryptor dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start        (start),
    .plaintext_i  (plaintext_i),
    .key_i        (key_i),
    .data_ready_o (data_ready_o),
    .busy_o       (busy_o),
    .valid_o      (valid_o),
    .ciphertext_o (ciphertext_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Polynomial product reduced by long division modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  logic [7:0] sbox_t [256];

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [127:0] ref_aes(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   w [176];
    logic [7:0]   st [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [7:0]   x;
    logic [7:0]   rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      w[i]  = key[127-8*i -: 8];
      st[i] = pt[127-8*i -: 8] ^ w[i];
    end
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        x = tmp[0]; tmp[0] = tmp[1]; tmp[1] = tmp[2]; tmp[2] = tmp[3]; tmp[3] = x;
        for (int j = 0; j < 4; j++) tmp[j] = sbox_t[tmp[j]];
        tmp[0] = tmp[0] ^ rc;
        rc = ref_mul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox_t[st[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr+4*c] = st[rr+4*((c+rr)%4)];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          st[4*c+rr] = (r < 10) ? (ref_mul(8'h02, t[4*c+rr]) ^ ref_mul(8'h03, t[4*c+(rr+1)%4])
                                  ^ t[4*c+(rr+2)%4] ^ t[4*c+(rr+3)%4])
                                : t[4*c+rr];
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[16*r+i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic launch(input logic [127:0] k, input logic [127:0] p);
    @(negedge clk_i);
    key_i = k; plaintext_i = p; start = 1'b1;
    @(posedge clk_i);
    #1;
    start = 1'b0;
    key_i = rnd128(); plaintext_i = rnd128();
    check("accept_busy_ready", {busy_o, data_ready_o}, 2'b10);
  endtask

  task automatic wait_result(input string tag, input logic [127:0] exp, input bit noisy);
    int cnt;
    bit busy_ok;
    cnt = 0;
    busy_ok = 1'b1;
    while (!valid_o && cnt < 20) begin
      if (noisy) begin
        @(negedge clk_i);
        start = 1'($urandom_range(0, 1));
        key_i = rnd128(); plaintext_i = rnd128();
      end
      @(posedge clk_i);
      #1;
      cnt++;
      if (!valid_o && (!busy_o || data_ready_o)) busy_ok = 1'b0;
    end
    start = 1'b0;
    check({tag, "_latency"}, cnt, 10);
    check({tag, "_busy_during_run"}, busy_ok, 1'b1);
    check({tag, "_done_flags"}, {valid_o, busy_o, data_ready_o}, 3'b101);
    check({tag, "_ciphertext"}, ciphertext_o, exp);
  endtask

  task automatic check_hold(input string tag, input logic [127:0] exp);
    @(posedge clk_i);
    #1;
    check({tag, "_valid_drop"}, valid_o, 1'b0);
`ifdef AES128_CT_MASK_EN
    check({tag, "_ct_masked"}, ciphertext_o, 128'h0);
`else
    check({tag, "_ct_held"}, ciphertext_o, exp);
`endif
  endtask

  initial begin
    logic [127:0] k, p, e;
    bit seen_valid;

    build_sbox();
    rst_i = 1'b1; start = 1'b0; key_i = '0; plaintext_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("reset_flags", {data_ready_o, busy_o, valid_o}, 3'b100);
    check("reset_ct", ciphertext_o, 128'h0);

    launch(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734);
    wait_result("fips_b", 128'h3925841d02dc09fbdc118597196a0b32, 1'b0);
    check_hold("fips_b", 128'h3925841d02dc09fbdc118597196a0b32);

    launch(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff);
    wait_result("fips_c1_noisy", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1);
    check_hold("fips_c1", 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    launch(128'h0, 128'h0);
    wait_result("zero", 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1'b0);
    k = rnd128(); p = rnd128(); e = ref_aes(k, p);
    launch(k, p);
    wait_result("back_to_back", e, 1'b0);
    check_hold("back_to_back", e);

    for (int i = 0; i < 6; i++) begin
      k = rnd128(); p = rnd128(); e = ref_aes(k, p);
      launch(k, p);
      wait_result("random", e, 1'(i % 2));
      if (i % 3 == 2) check_hold("random", e);
    end

    launch(rnd128(), rnd128());
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("midreset_flags", {data_ready_o, busy_o, valid_o}, 3'b100);
    check("midreset_ct", ciphertext_o, 128'h0);
    seen_valid = 1'b0;
    repeat (15) begin
      @(posedge clk_i);
      #1;
      seen_valid = seen_valid | valid_o;
    end
    check("midreset_no_valid", seen_valid, 1'b0);

    k = rnd128(); p = rnd128(); e = ref_aes(k, p);
    launch(k, p);
    wait_result("after_reset", e, 1'b0);
    check_hold("after_reset", e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
